// File: rtl/seq_div16_if.sv
// Operand/result bundle for the sequential divider.
// Handshake: the master raises start with operands valid; it is taken on a rising
// edge only when busy==0. done is a one-cycle pulse, and the results are valid from it.
interface seq_div16_if #(parameter int WIDTH = 16);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_div16.sv
// Unsigned restoring divider: one quotient bit per clock, done after WIDTH iterations.
// A zero divisor skips the loop and reports all-ones quotient with the dividend as remainder.
module seq_div16 #(
   parameter int WIDTH = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   seq_div16_if.slave  bus,
   output logic [1:0]  o_dbg_state
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_r;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_d;
   logic [CW-1:0]    r_cnt;
   logic             r_dbz;
   logic             w_accept;
   logic             w_last;
   logic [WIDTH-1:0] w_shift;
   logic [WIDTH:0]   w_trial;

   // Partial remainder after the shift; the trial subtraction borrows into bit WIDTH.
   assign w_shift = {r_r[WIDTH-2:0], r_q[WIDTH-1]};
   assign w_trial = {1'b0, w_shift} - {1'b0, r_d};
   assign w_last  = (r_cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               w_accept = 1'b1;
               w_next   = (bus.divisor == '0) ? S_DONE : S_RUN;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_RUN:   if (w_last) w_next = S_DONE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_r   <= '0;
         r_q   <= '0;
         r_d   <= '0;
         r_cnt <= '0;
         r_dbz <= 1'b0;
      end else if (w_accept) begin
         r_d   <= bus.divisor;
         r_cnt <= '0;
         if (bus.divisor == '0) begin
            r_q   <= '1;
            r_r   <= bus.dividend;
            r_dbz <= 1'b1;
         end else begin
            r_q   <= bus.dividend;
            r_r   <= '0;
            r_dbz <= 1'b0;
         end
      end else if (r_state == S_RUN) begin
         r_cnt <= r_cnt + CW'(1);
         if (!w_trial[WIDTH]) begin
            r_r <= w_trial[WIDTH-1:0];
            r_q <= {r_q[WIDTH-2:0], 1'b1};
         end else begin
            r_r <= w_shift;
            r_q <= {r_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   assign bus.busy        = (r_state == S_RUN);
   assign bus.done        = (r_state == S_DONE);
   assign bus.quotient    = r_q;
   assign bus.remainder   = r_r;
   assign bus.div_by_zero = r_dbz;
   assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_seq_div16.sv
// Directed bench for seq_div16: hand-computed quotients, latency and handshake corner cases.
module tb_seq_div16;
   logic       clk;
   logic       rst_n;
   logic [1:0] dbg_state;
   int         checks;
   int         errors;

   seq_div16_if #(.WIDTH(16)) bus ();

   seq_div16 #(.WIDTH(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Returns #1 after the edge that samples start.
   task automatic do_start(input logic [15:0] dvd, input logic [15:0] dvs);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = dvd;
      bus.divisor  = dvs;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // Counts edges until done is seen; lat stays 0 if done is already high.
   task automatic wait_done(output int lat, output bit seen);
      lat  = 0;
      seen = bus.done;
      while (!seen && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         seen = bus.done;
      end
   endtask

   task automatic check_result(input string name, input int lat, input bit seen, input int exp_lat,
                               input logic [15:0] exp_q, input logic [15:0] exp_r, input logic exp_dbz);
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s timeout: done not seen within 40 cycles", name);
      end
      checks++;
      if (lat !== exp_lat) begin
         errors++;
         $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
      end
      checks++;
      if (bus.quotient !== exp_q) begin
         errors++;
         $display("FAIL %s quotient: got %0d expected %0d", name, bus.quotient, exp_q);
      end
      checks++;
      if (bus.remainder !== exp_r) begin
         errors++;
         $display("FAIL %s remainder: got %0d expected %0d", name, bus.remainder, exp_r);
      end
      checks++;
      if (bus.div_by_zero !== exp_dbz) begin
         errors++;
         $display("FAIL %s div_by_zero: got %b expected %b", name, bus.div_by_zero, exp_dbz);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL %s busy_at_done: got %b expected 0", name, bus.busy);
      end
   endtask

   task automatic test_reset;
      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 000", {bus.busy, bus.done, bus.div_by_zero});
      end
      checks++;
      if ({bus.quotient, bus.remainder} !== 32'h0) begin
         errors++;
         $display("FAIL reset_results: got %h expected 0", {bus.quotient, bus.remainder});
      end
      checks++;
      if (dbg_state !== 2'd0) begin
         errors++;
         $display("FAIL reset_state: got %0d expected 0", dbg_state);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic;
      int lat;
      bit seen;
      do_start(16'd15, 16'd5);
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy_after_start: got %b expected 1", bus.busy);
      end
      wait_done(lat, seen);
      check_result("basic_15_5", lat, seen, 16, 16'd3, 16'd0, 1'b0);
      @(posedge clk);
      #1;
      checks++;
      if (bus.done !== 1'b0) begin
         errors++;
         $display("FAIL basic_done_one_cycle: got %b expected 0", bus.done);
      end
      checks++;
      if ({bus.quotient, bus.remainder} !== {16'd3, 16'd0}) begin
         errors++;
         $display("FAIL basic_hold_in_idle: got %h expected %h", {bus.quotient, bus.remainder}, {16'd3, 16'd0});
      end
   endtask

   task automatic test_values;
      int lat;
      bit seen;
      do_start(16'd6896, 16'd1234);
      wait_done(lat, seen);
      check_result("div_6896_1234", lat, seen, 16, 16'd5, 16'd726, 1'b0);
      do_start(16'd65535, 16'd1);
      wait_done(lat, seen);
      check_result("div_65535_1", lat, seen, 16, 16'd65535, 16'd0, 1'b0);
   endtask

   task automatic test_div_zero;
      int lat;
      bit seen;
      // done is already high in the cycle right after the start edge.
      do_start(16'd1234, 16'd0);
      wait_done(lat, seen);
      check_result("div_by_zero", lat, seen, 0, 16'hFFFF, 16'd1234, 1'b1);
      do_start(16'd100, 16'd7);
      wait_done(lat, seen);
      check_result("after_dbz_100_7", lat, seen, 16, 16'd14, 16'd2, 1'b0);
   endtask

   task automatic test_back_to_back;
      int lat;
      bit seen;
      do_start(16'd1000, 16'd3);
      repeat (4) @(posedge clk);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 16'd9;
      bus.divisor  = 16'd9;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(lat, seen);
      check_result("ignored_start_1000_3", lat + 5, seen, 16, 16'd333, 16'd1, 1'b0);
      // Start raised inside the done cycle must be taken on the very next edge.
      bus.start    = 1'b1;
      bus.dividend = 16'd32768;
      bus.divisor  = 16'd32768;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      checks++;
      if ({bus.busy, bus.done} !== 2'b10) begin
         errors++;
         $display("FAIL b2b_no_idle: got busy,done=%b expected 10", {bus.busy, bus.done});
      end
      wait_done(lat, seen);
      check_result("b2b_32768_32768", lat, seen, 16, 16'd1, 16'd0, 1'b0);
   endtask

   task automatic test_reset_mid_run;
      int lat;
      bit seen;
      int done_cnt;
      do_start(16'd40000, 16'd7);
      repeat (8) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== 35'h0) begin
         errors++;
         $display("FAIL midrun_reset_outputs: got busy=%b done=%b dbz=%b q=%0d r=%0d expected all 0",
                  bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
      end
      done_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) done_cnt++;
      end
      checks++;
      if (done_cnt !== 0) begin
         errors++;
         $display("FAIL midrun_reset_no_done: got %0d pulses expected 0", done_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_start(16'd40000, 16'd7);
      wait_done(lat, seen);
      check_result("after_reset_40000_7", lat, seen, 16, 16'd5714, 16'd2, 1'b0);
   endtask

   task automatic test_edges;
      int lat;
      bit seen;
      do_start(16'd0, 16'd9);
      wait_done(lat, seen);
      check_result("div_0_9", lat, seen, 16, 16'd0, 16'd0, 1'b0);
      do_start(16'd5, 16'd65535);
      wait_done(lat, seen);
      check_result("div_5_65535", lat, seen, 16, 16'd0, 16'd5, 1'b0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset;
      test_basic;
      test_values;
      test_div_zero;
      test_back_to_back;
      test_reset_mid_run;
      test_edges;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
